spi_reg_arbiter: RTL

//  Shares one single-port 8-bit register RAM between the SPI-slave command path
//  and the APB register path, all in the sys_clk domain.

---
 rtl/spi_reg_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/spi_reg_arbiter.sv
// Round-robin arbiter sharing one single-port 8-bit register RAM between the SPI and APB paths.
// Optional SPI write protection above WP_BASE is enabled by defining SPI_ARB_WPROT_EN.
//
// state | meaning
// IDLE  | waiting for a request; grant and launch the RAM access
// ACC   | mem_en high, RAM performs the access
// CAP   | mem_rdata valid; capture read data, arm the winner's ack
// ACK   | winner's ack high; requests ignored
module spi_reg_arbiter #(
  parameter int              AW      = 8,
  parameter logic [AW-1:0]   WP_BASE = AW'(8'hF0)
) (
  input  logic          sys_clk,
  input  logic          rst_b,
  input  logic          spi_req,
  input  logic          spi_wr,
  input  logic [AW-1:0] spi_addr,
  input  logic [7:0]    spi_wdata,
  output logic          spi_ack,
  output logic [7:0]    spi_rdata,
  input  logic          apb_req,
  input  logic          apb_wr,
  input  logic [AW-1:0] apb_addr,
  input  logic [7:0]    apb_wdata,
  output logic          apb_ack,
  output logic [7:0]    apb_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  output logic          owner_spi,
  output logic          wp_err
);

`ifdef SPI_ARB_WPROT_EN
  localparam bit WPROT_ON = 1'b1;
`else
  localparam bit WPROT_ON = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ACC, CAP, ACK} state_t;

  state_t        state, state_nxt;
  logic          last_spi;
  logic          lat_wr;
  logic          grant_any, grant_spi, grant_wr, wp_hit;
  logic [AW-1:0] grant_addr;
  logic [7:0]    grant_wdata;

  always_ff @(posedge sys_clk) begin
    if (!rst_b) state <= IDLE;
    else        state <= state_nxt;
  end

  // With both requests pending, SPI wins unless it won the previous contest.
  always_comb begin
    grant_any   = spi_req | apb_req;
    grant_spi   = spi_req & (~apb_req | ~last_spi);
    grant_wr    = grant_spi ? spi_wr    : apb_wr;
    grant_addr  = grant_spi ? spi_addr  : apb_addr;
    grant_wdata = grant_spi ? spi_wdata : apb_wdata;
    wp_hit      = WPROT_ON & grant_spi & grant_wr & (grant_addr >= WP_BASE);
    state_nxt   = state;
    case (state)
      IDLE:    if (grant_any) state_nxt = ACC;
      ACC:     state_nxt = CAP;
      CAP:     state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_b) begin
      last_spi  <= 1'b0;
      lat_wr    <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      owner_spi <= 1'b0;
      spi_ack   <= 1'b0;
      apb_ack   <= 1'b0;
      spi_rdata <= '0;
      apb_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            mem_en    <= 1'b1;
            mem_we    <= grant_wr & ~wp_hit;
            mem_addr  <= grant_addr;
            mem_wdata <= grant_wdata;
            lat_wr    <= grant_wr;
            owner_spi <= grant_spi;
            if (spi_req && apb_req) last_spi <= grant_spi;
          end
        end
        ACC: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
        end
        CAP: begin
          // A suppressed write still counts as a write: read data is not captured.
          if (!lat_wr) begin
            if (owner_spi) spi_rdata <= mem_rdata;
            else           apb_rdata <= mem_rdata;
          end
          if (owner_spi) spi_ack <= 1'b1;
          else           apb_ack <= 1'b1;
        end
        ACK: begin
          spi_ack   <= 1'b0;
          apb_ack   <= 1'b0;
          owner_spi <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef SPI_ARB_WPROT_EN
  always_ff @(posedge sys_clk) begin
    if (!rst_b)                      wp_err <= 1'b0;
    else if (state == IDLE && wp_hit) wp_err <= 1'b1;
  end
`else
  assign wp_err = 1'b0;
`endif

endmodule
